// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Single-stage instruction fetch with a synchronous instruction ROM,
//            stall skid buffer and branch redirect (one bubble per redirect).
// Ports    : enable        - clock, state updates on its rising edge
//            reset         - asynchronous active-low reset
//            PC_write      - 1 = advance fetch, 0 = stall (hold)
//            branch_taken  - 1 = redirect to branch_target, kills slot instr
//            branch_target - word address of redirect target
//            imem_data     - ROM read data, valid one cycle after imem_addr
//            imem_addr     - word address to ROM (equals internal PC)
//            instruc_out   - fetched instruction, 0 = bubble
//            PC_plus_1_out - address of instruc_out plus 1 (0 on bubble)
//            fetch_valid   - instruc_out holds a real instruction
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch (
    input  logic        enable,
    input  logic        reset,
    input  logic        PC_write,
    input  logic        branch_taken,
    input  logic [9:0]  branch_target,
    input  logic [31:0] imem_data,
    output logic [9:0]  imem_addr,
    output logic [31:0] instruc_out,
    output logic [9:0]  PC_plus_1_out,
    output logic        fetch_valid
);

    logic [9:0]  r_pc;          // next fetch address
    logic [9:0]  r_f_pc;        // address of the instruction in the output slot
    logic        r_f_valid;
    logic        r_skid_valid;
    logic [31:0] r_skid_data;

    always_ff @(posedge enable or negedge reset) begin
        if (!reset) begin
            r_pc         <= 10'd0;
            r_f_pc       <= 10'd0;
            r_f_valid    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= 32'd0;
        end else if (branch_taken) begin
            // Redirect wins over stall; any skidded instruction is dropped.
            r_pc         <= branch_target;
            r_f_valid    <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (PC_write) begin
            r_f_pc       <= r_pc;
            r_pc         <= r_pc + 10'd1;
            r_f_valid    <= 1'b1;
            r_skid_valid <= 1'b0;
        end else if (r_f_valid && !r_skid_valid) begin
            // First stall edge: the ROM is about to move on to PC (already
            // f_pc+1), so the slot instruction must be captured now.
            r_skid_data  <= imem_data;
            r_skid_valid <= 1'b1;
        end
    end

    assign imem_addr     = r_pc;
    assign fetch_valid   = r_f_valid;
    assign PC_plus_1_out = r_f_valid ? (r_f_pc + 10'd1) : 10'd0;

    always_comb begin
        instruc_out = imem_data;
        if (!r_f_valid)
            instruc_out = 32'd0;
        else if (r_skid_valid)
            instruc_out = r_skid_data;
    end

endmodule
`default_nettype wire
